// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) reduction constant, xtime helper and the
// MixColumns engine state encoding.
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcol_engine_if.sv
// Request/response bundle of the MixColumns engine.
interface aes_mixcol_engine_if;
    import aes_pkg::*;

    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid and its payload stay stable until then.
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    mc_state_e    dbg_state;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy, dbg_state
    );

endinterface

// File: rtl/aes_mixcol_column.sv
// One-column MixColumns / InvMixColumns; the inverse is a pre-multiplication
// stage folded into the forward circulant.
module aes_mixcol_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);

    logic [7:0] w_a, w_b, w_c, w_d;
    logic [7:0] w_u, w_v;
    logic [7:0] w_pa, w_pb, w_pc, w_pd;

    assign {w_a, w_b, w_c, w_d} = i_col;

    assign w_u = i_inv ? xtime(xtime(w_a ^ w_c)) : 8'h00;
    assign w_v = i_inv ? xtime(xtime(w_b ^ w_d)) : 8'h00;

    assign w_pa = w_a ^ w_u;
    assign w_pb = w_b ^ w_v;
    assign w_pc = w_c ^ w_u;
    assign w_pd = w_d ^ w_v;

    // Multiplication by 3 is xtime(x) ^ x.
    assign o_col = {
        xtime(w_pa) ^ xtime(w_pb) ^ w_pb ^ w_pc ^ w_pd,
        w_pa ^ xtime(w_pb) ^ xtime(w_pc) ^ w_pc ^ w_pd,
        w_pa ^ w_pb ^ xtime(w_pc) ^ xtime(w_pd) ^ w_pd,
        xtime(w_pa) ^ w_pa ^ w_pb ^ w_pc ^ xtime(w_pd)
    };

endmodule

// File: rtl/aes_mixcol_engine.sv
// Sequential MixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, then presents the result until taken.
module aes_mixcol_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    aes_mixcol_engine_if.slave  bus
);

    localparam int N_STEPS = 4 / COLS_PER_CYCLE;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e       r_state;
    mc_state_e       w_state_nx;
    logic [1:0]      r_cnt;
    logic            r_inv;
    logic [0:3][31:0] r_work;
    logic [0:3][31:0] w_work_nx;
    logic [127:0]    r_out;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_last_step;

    logic [31:0] w_col_in  [COLS_PER_CYCLE];
    logic [31:0] w_col_out [COLS_PER_CYCLE];
    logic [1:0]  w_col_idx [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign w_col_idx[g] = 2'(int'(r_cnt) * COLS_PER_CYCLE + g);
        assign w_col_in[g]  = r_work[w_col_idx[g]];

        aes_mixcol_column u_col (
            .i_col (w_col_in[g]),
            .i_inv (r_inv),
            .o_col (w_col_out[g])
        );
    end

    always_comb begin
        w_work_nx = r_work;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            w_work_nx[w_col_idx[i]] = w_col_out[i];
        end
    end

    assign w_last_step = (r_state == ST_BUSY) && (r_cnt == 2'(N_STEPS - 1));

    always_comb begin
        w_state_nx = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last_step) w_state_nx = ST_DONE;
            end
            ST_DONE: begin
                // Handing off the result frees the engine in the same cycle.
                if (bus.out_ready) begin
                    w_in_ready = 1'b1;
                    w_state_nx = bus.in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_accept = w_in_ready & bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_inv   <= 1'b0;
            r_work  <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_work <= bus.in_data;
                r_inv  <= bus.in_inv;
                r_cnt  <= 2'd0;
            end else if (r_state == ST_BUSY) begin
                r_work <= w_work_nx;
                r_cnt  <= r_cnt + 2'd1;
            end
            // Separate output register so out_data never shows a state in progress.
            if (w_last_step) r_out <= w_work_nx;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_data  = r_out;
    assign bus.busy      = (r_state == ST_BUSY);
    assign bus.dbg_state = r_state;

endmodule

// File: doc/aes_mixcol_engine.md
Name: aes_mixcol_engine

Overview:
Sequential AES MixColumns / InvMixColumns engine operating on a full 128-bit AES state. The engine accepts one state per valid/ready handshake and transforms COLS_PER_CYCLE columns per clock, so area trades against throughput. The mode (forward or inverse) is selected per transaction. It sits between ShiftRows and AddRoundKey in the round datapath and is reused by the encrypt and decrypt round controllers.

Parameters:
COLS_PER_CYCLE, 1, number of 32-bit columns transformed per clock; legal values are 1, 2 and 4, and any other value is an elaboration error.
N_STEPS, 4/COLS_PER_CYCLE, derived localparam giving the number of BUSY cycles per state; it is not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  a state is offered on in_data
in_ready  output  1  the engine can accept a state
in_data  input  128  input state; column c = bits [127-32c -: 32], row 0 byte is the MSB of the column
in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on accept
out_valid  output  1  out_data holds a finished result
out_ready  input  1  the consumer accepts out_data
out_data  output  128  transformed state, same byte layout as in_data
busy  output  1  high in BUSY

Behaviour:
- Clocking: one clock (clk); reset rst is asynchronous and active-high.
- Reset: FSM goes to IDLE, column counter = 0, working register = 0, mode flag = 0. Outputs: out_valid = 0, out_data = 0, busy = 0, in_ready = 1 once rst deasserts.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, load in_data into the working register, latch in_inv, clear the counter, go to BUSY.
  - BUSY: each cycle, columns [cnt*COLS_PER_CYCLE +: COLS_PER_CYCLE] of the working register are replaced by their transform, then cnt increments. When cnt == N_STEPS-1, go to DONE.
  - DONE: out_valid = 1 and out_data = working register, held stable until out_ready. On out_ready, go to IDLE, unless a new state is accepted in the same cycle, in which case go directly to BUSY.
- in_ready = (state == IDLE) | (state == DONE & out_ready). This gives a back-to-back throughput of one state per N_STEPS+1 cycles.
- Latency: a state accepted at edge k produces out_valid high from edge k+N_STEPS (4, 2 or 1 cycles).
- Forward column transform (a, b, c, d = rows 0..3):
  - o0 = 2a^3b^c^d
  - o1 = a^2b^3c^d
  - o2 = a^b^2c^3d
  - o3 = 3a^b^c^2d
- Inverse column transform uses coefficients 0e, 0b, 0d, 09 in the same circulant arrangement. It may be implemented as a pre-multiplication followed by the forward transform:
  - u = xtime(xtime(a^c)), v = xtime(xtime(b^d))
  - feed (a^u, b^v, c^u, d^v) into the forward transform
- xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0); all arithmetic is GF(2^8), 8 bits wide.
- in_data and in_inv are ignored except on an accept cycle. Changing them while BUSY has no effect.
- out_data is only meaningful while out_valid = 1, but it holds the last result otherwise; it never shows a partial result in DONE.
- Reset asserted mid-transaction aborts immediately; no output is produced for the aborted state.
- out_ready asserted while not in DONE is ignored.

Decomposition:
- Shared AES package (aes_pkg): the xtime function, the GF constant 8'h1b, and the FSM state encoding (IDLE, BUSY, DONE; 2 bits).
- Sub-module aes_mixcol_column: combinational, 32-bit column in, inv select, 32-bit column out. It covers both modes and is instantiated COLS_PER_CYCLE times.
- Column selection and counter logic live in the top module.

Test Plan:
1. Forward, COLS_PER_CYCLE=1: in_data = db135345_f20a225c_01010101_2d26314c, in_inv=0 -> out_data = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid exactly 4 cycles after accept.
2. Inverse, COLS_PER_CYCLE=4: in_data = 8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, in_inv=1 -> out_data = db135345_f20a225c_c6c6c6c6_d4d4d4d5, latency 1 cycle.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; then pulse out_ready with in_valid=1 -> the new state is accepted in the same cycle and out_valid drops for exactly N_STEPS cycles.
4. Round trip, COLS_PER_CYCLE=2: 1000 random states, forward then inverse -> each returns to the original state; every forward result matches a reference model.
5. Mid-operation reset: accept a state, assert rst in the 2nd BUSY cycle -> out_valid=0, busy=0 and in_ready=1 after release; the next state 01010101_x4 yields 01010101_x4 with correct latency.
6. Input instability: toggle in_data and in_inv every cycle while BUSY -> the result matches the accepted values only.
